// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Data-side memory responder at the far end of the core's memory-stage bus.
// Accepts one load or store at a time, waits a fixed LATENCY, then commits
// the store (per-byte enables) into a RAM of 128-bit lines or returns the
// addressed line for a load, pulsing data_ready for one cycle.
//
// Parameters:
//   DEPTH   - number of 128-bit lines (power of two, >= 2)
//   LATENCY - cycles from request sample to data_ready (1..15)
//
// Ports:
//   clock              - rising-edge clock
//   sync_reset         - synchronous active-high reset (aborts any transaction)
//   memory_transaction - request valid, held by the core until data_ready
//   mem_write          - 1 = store, 0 = load
//   ALU_result         - byte address; line index is ALU_result[AW+3:4]
//   data_out_bus       - 128-bit store data, line aligned
//   byte_enablers      - bit i enables byte i of the line on a store
//   read_data_bus      - load data; changes only on load completion or reset
//   data_ready         - one-cycle completion pulse
//   access_error       - out-of-range flag, coincident with data_ready
//
// Build option:
//   DMEM_RANGE_CHECK_EN - when defined, addresses >= DEPTH*16 suppress stores,
//                         return zeros for loads and raise access_error.
//                         When undefined, upper address bits alias and
//                         access_error is tied low.

module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic         clock,
  input  logic         sync_reset,
  input  logic         memory_transaction,
  input  logic         mem_write,
  input  logic [31:0]  ALU_result,
  input  logic [127:0] data_out_bus,
  input  logic [15:0]  byte_enablers,
  output logic [127:0] read_data_bus,
  output logic         data_ready,
  output logic         access_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture;
  logic       commit;
  logic       commit_do;

  // Request decode from the live bus
  logic [AW-1:0] req_idx;
  logic          req_oor;

  // Captured request held for the whole transaction
  logic [AW-1:0] idx_p0;
  logic          wr_p0;
  logic          oor_p0;
  logic [127:0]  wdata_p0;
  logic [15:0]   be_p0;

  // Commit-time source: live bus when committing straight from IDLE
  // (LATENCY=1), otherwise the captured request
  logic [AW-1:0] src_idx;
  logic          src_wr;
  logic          src_oor;
  logic [127:0]  src_data;
  logic [15:0]   src_be;

  logic rsp_err_p1;

  logic [127:0] mem [DEPTH];

  function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                               input logic [127:0] new_line,
                                               input logic [15:0]  be);
    logic [127:0] res;
    res = old_line;
    for (int i = 0; i < 16; i++) begin
      if (be[i]) res[8*i +: 8] = new_line[8*i +: 8];
    end
    return res;
  endfunction

  assign req_idx = ALU_result[AW+3:4];

`ifdef DMEM_RANGE_CHECK_EN
  assign req_oor = (ALU_result >= 32'(DEPTH * 16));
`else
  assign req_oor = 1'b0;
`endif

  // Offset bits never select anything; upper bits only matter for the
  // optional range check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALU_result[31:AW+4], ALU_result[3:0]};

  assign src_idx  = (state == IDLE) ? req_idx        : idx_p0;
  assign src_wr   = (state == IDLE) ? mem_write      : wr_p0;
  assign src_oor  = (state == IDLE) ? req_oor        : oor_p0;
  assign src_data = (state == IDLE) ? data_out_bus   : wdata_p0;
  assign src_be   = (state == IDLE) ? byte_enablers  : be_p0;

  // Reset has priority: nothing commits on a reset edge.
  assign commit_do = commit & ~sync_reset;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (memory_transaction) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control stage: state, counter, response flags
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      read_data_bus <= '0;
      rsp_err_p1    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit_do) begin
        rsp_err_p1 <= src_oor;
        if (!src_wr) read_data_bus <= src_oor ? '0 : mem[src_idx];
      end
    end
  end

  // Capture stage: request payload
  always_ff @(posedge clock) begin
    if (capture) begin
      idx_p0   <= req_idx;
      wr_p0    <= mem_write;
      oor_p0   <= req_oor;
      wdata_p0 <= data_out_bus;
      be_p0    <= byte_enablers;
    end
  end

  // Commit stage: line RAM write
  always_ff @(posedge clock) begin
    if (commit_do && src_wr && !src_oor) begin
      mem[src_idx] <= merge_bytes(mem[src_idx], src_data, src_be);
    end
  end

  assign data_ready   = (state == RESP);
  assign access_error = (state == RESP) & rsp_err_p1;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic         clock = 1'b0;
  logic         sync_reset;
  logic         memory_transaction;
  logic         mem_write;
  logic [31:0]  ALU_result;
  logic [127:0] data_out_bus;
  logic [15:0]  byte_enablers;
  logic [127:0] read_data_bus;
  logic         data_ready;
  logic         access_error;

  int errors = 0;
  int checks = 0;

  // Reference model: plain array of lines plus the expected load register
  logic [127:0] ref_mem [DEPTH];
  logic [127:0] exp_rd;
  int           lines [8] = '{0, 4, 5, 17, 100, 200, 254, 255};

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock              (clock),
    .sync_reset         (sync_reset),
    .memory_transaction (memory_transaction),
    .mem_write          (mem_write),
    .ALU_result         (ALU_result),
    .data_out_bus       (data_out_bus),
    .byte_enablers      (byte_enablers),
    .read_data_bus      (read_data_bus),
    .data_ready         (data_ready),
    .access_error       (access_error)
  );

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'(DEPTH * 16);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_data_ready"}, 128'(data_ready), 128'(0));
    chk({tag, "_access_error"}, 128'(access_error), 128'(0));
    chk({tag, "_read_data_bus"}, read_data_bus, exp_rd);
  endtask

  // One complete transaction; optionally disturbs the bus during BUSY.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [127:0] d,
                     input logic [15:0] be, input bit glitch);
    int idx;
    bit oor;
    idx = int'((addr / 16) % DEPTH);
    oor = is_oor(addr);
    @(negedge clock);
    memory_transaction = 1'b1;
    mem_write          = wr;
    ALU_result         = addr;
    data_out_bus       = d;
    byte_enablers      = be;
    @(posedge clock);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clock);
      #1;
      if (k == LAT) begin
        if (wr && !oor)
          for (int b = 0; b < 16; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        if (!wr) exp_rd = oor ? 128'd0 : ref_mem[idx];
      end
      chk(wr ? "st_data_ready" : "ld_data_ready", 128'(data_ready), 128'(k == LAT));
      chk(wr ? "st_access_error" : "ld_access_error", 128'(access_error), 128'((k == LAT) && oor));
      chk(wr ? "st_read_data_bus" : "ld_read_data_bus", read_data_bus, exp_rd);
      if (k == 1 && glitch) begin
        memory_transaction = 1'b0;
        data_out_bus       = ~d;
        byte_enablers      = ~be;
        ALU_result         = addr ^ 32'h0000_0050;
        mem_write          = ~wr;
      end
      if (k == LAT) memory_transaction = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] rnd;
    logic [31:0]  a;
    int           ln;

    sync_reset         = 1'b1;
    memory_transaction = 1'b0;
    mem_write          = 1'b0;
    ALU_result         = 32'd0;
    data_out_bus       = '0;
    byte_enablers      = '0;
    exp_rd             = '0;

    // Reset and idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    sync_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check_idle("idle");
    end

    // Full-line store then load
    txn(1'b1, 32'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 1'b0);
    txn(1'b0, 32'h40, '0, 16'h0000, 1'b0);
    chk("full_line_value", exp_rd, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Partial store, load via unaligned address in same line
    txn(1'b1, 32'h40, {96'h0, 32'hDEADBEEF}, 16'h000F, 1'b0);
    txn(1'b0, 32'h4C, '0, 16'h0000, 1'b0);
    chk("partial_line_value", read_data_bus, 128'h00112233_44556677_8899AABB_DEADBEEF);

    // All-zero enables modify nothing
    txn(1'b1, 32'h44, {4{32'hA5A5A5A5}}, 16'h0000, 1'b0);
    txn(1'b0, 32'h40, '0, 16'h0000, 1'b0);

    // Bus disturbed during BUSY: captured request still commits
    txn(1'b1, 32'h40, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C, 16'hF0F0, 1'b1);
    txn(1'b0, 32'h40, '0, 16'h0000, 1'b0);

    // Reset the cycle after a store is sampled: aborted, no pulse
    @(negedge clock);
    memory_transaction = 1'b1;
    mem_write          = 1'b1;
    ALU_result         = 32'h40;
    data_out_bus       = {4{32'h77777777}};
    byte_enablers      = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    sync_reset         = 1'b1;
    memory_transaction = 1'b0;
    @(posedge clock);
    #1;
    exp_rd = '0;
    check_idle("abort_reset");
    @(negedge clock);
    sync_reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clock);
      #1;
      check_idle("abort_after");
    end
    txn(1'b0, 32'h40, '0, 16'h0000, 1'b0);

    // Initialise the remaining lines with full stores
    for (int i = 0; i < 8; i++) begin
      if (lines[i] != 4) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 32'(lines[i] * 16), rnd, 16'hFFFF, 1'b0);
      end
    end

    // Range / alias boundary
    txn(1'b0, 32'h2000, '0, 16'h0000, 1'b0);
    txn(1'b0, 32'h2040, '0, 16'h0000, 1'b0);
    txn(1'b1, 32'h2040, {4{32'h5A5A5A5A}}, 16'h00FF, 1'b0);
    txn(1'b0, 32'h40, '0, 16'h0000, 1'b0);
    txn(1'b0, 32'h0000_0FF0, '0, 16'h0000, 1'b0);

    // Randomised traffic over the initialised lines
    for (int i = 0; i < 40; i++) begin
      ln  = lines[$urandom_range(0, 7)];
      a   = (32'($urandom_range(0, 3)) << 12) | 32'(ln * 16) | 32'($urandom_range(0, 15));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      txn(1'($urandom_range(0, 1)), a, rnd, 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Read back every tracked line
    for (int i = 0; i < 8; i++) txn(1'b0, 32'(lines[i] * 16), '0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
